// File: rtl/mem_run_controller_if.sv
// Signal bundle between the run controller, the UART command decoder, the memory manager
// and the UART transmitter. The controller uses the master view; the environment uses slave.
interface mem_run_controller_if #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PARAMS_W = 32,
    parameter int unsigned CTR_W    = 16
);
    logic                       cmd_start;
    logic                       cmd_stop;
    logic [PARAMS_W-1:0]        cmd_params;
    logic [CTR_W-1:0]           cmd_word_count;
    logic                       run;
    logic [PARAMS_W-1:0]        mem_params;
    logic [ADDR_W+DATA_W-1:0]   mem_received_num;
    logic                       mem_valid;
    logic                       mem_overrun;
    logic                       mem_ack;
    logic [ADDR_W+DATA_W-1:0]   tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       busy;
    logic                       done;
    logic                       error;
    logic [CTR_W-1:0]           words_forwarded;

    modport master (
        input  cmd_start, cmd_stop, cmd_params, cmd_word_count,
        input  mem_received_num, mem_valid, mem_overrun, tx_ready,
        output run, mem_params, mem_ack, tx_data, tx_valid,
        output busy, done, error, words_forwarded
    );

    modport slave (
        output cmd_start, cmd_stop, cmd_params, cmd_word_count,
        output mem_received_num, mem_valid, mem_overrun, tx_ready,
        input  run, mem_params, mem_ack, tx_data, tx_valid,
        input  busy, done, error, words_forwarded
    );
endinterface

// File: rtl/mem_run_controller.sv
// Sequences one memory-manager test run: settle, enable, collect and forward received
// numbers through a one-entry holding buffer, then drain and report status.
module mem_run_controller #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned PARAMS_W      = 32,
    parameter int unsigned CTR_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DISCARD_FIRST = 1
) (
    input logic                  clk,
    input logic                  rst,
    mem_run_controller_if.master bus
);
    localparam int unsigned MSG_W = ADDR_W + DATA_W;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                first_q, first_d;
    logic [CTR_W-1:0]    count_q, count_d;
    logic [CTR_W-1:0]    fwd_q, fwd_d;
    logic [PARAMS_W-1:0] params_q, params_d;
    logic [MSG_W-1:0]    txd_q, txd_d;
    logic                txv_q, txv_d;
    logic                run_q, run_d;
    logic                ack_q, ack_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                hs;
    logic                capture;
    logic                drop;
    logic                count_hit;
    logic [CTR_W-1:0]    fwd_inc;

    assign hs = txv_q && bus.tx_ready;
    // The buffer may be refilled in the same cycle it is being handed off.
    assign capture = (state_q == S_RUN) && bus.mem_valid && !ack_q && (!txv_q || hs);
    assign drop = first_q && (DISCARD_FIRST != 0);
    assign fwd_inc = (&fwd_q) ? fwd_q : fwd_q + CTR_W'(1);
    assign count_hit = hs && (count_q != '0) && (fwd_inc == count_q);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        first_d  = first_q;
        count_d  = count_q;
        fwd_d    = fwd_q;
        params_d = params_q;
        txd_d    = txd_q;
        txv_d    = txv_q;
        run_d    = run_q;
        ack_d    = capture;
        done_d   = 1'b0;
        err_d    = err_q;

        if (hs) begin
            fwd_d = fwd_inc;
            txv_d = 1'b0;
        end
        if (capture) begin
            first_d = 1'b0;
            if (!drop) begin
                txd_d = bus.mem_received_num;
                txv_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    params_d = bus.cmd_params;
                    count_d  = bus.cmd_word_count;
                    err_d    = 1'b0;
                    fwd_d    = '0;
                    first_d  = 1'b1;
                    settle_d = SET_W'(SETTLE_CYCLES);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.cmd_stop) begin
                    state_d = S_DRAIN;
                end else if (settle_q == SET_W'(1)) begin
                    run_d   = 1'b1;
                    state_d = S_RUN;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            S_RUN: begin
                if (count_hit || bus.cmd_stop || bus.mem_overrun) begin
                    run_d   = 1'b0;
                    state_d = S_DRAIN;
                    if (bus.mem_overrun) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!txv_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            first_q  <= 1'b1;
            count_q  <= '0;
            fwd_q    <= '0;
            params_q <= '0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
            run_q    <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            first_q  <= first_d;
            count_q  <= count_d;
            fwd_q    <= fwd_d;
            params_q <= params_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            run_q    <= run_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.run             = run_q;
    assign bus.mem_params      = params_q;
    assign bus.mem_ack         = ack_q;
    assign bus.tx_data         = txd_q;
    assign bus.tx_valid        = txv_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = done_q;
    assign bus.error           = err_q;
    assign bus.words_forwarded = fwd_q;
endmodule

// File: tb/tb_mem_run_controller.sv
// Bench for mem_run_controller: transaction-level model plus directed and random runs.
module tb_mem_run_controller;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PARAMS_W = 32;
    localparam int unsigned CTR_W    = 16;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned DISCARD  = 1;
    localparam int unsigned MSG_W    = ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PARAMS_W(PARAMS_W),
                            .CTR_W(CTR_W)) bus ();

    mem_run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PARAMS_W(PARAMS_W), .CTR_W(CTR_W),
                         .SETTLE_CYCLES(SETTLE), .DISCARD_FIRST(DISCARD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus state
    bit                  s_start, s_stop, s_ovr, s_rdy;
    logic [PARAMS_W-1:0] s_params;
    logic [CTR_W-1:0]    s_wc;
    logic [MSG_W-1:0]    mgr_q[$];
    logic [MSG_W-1:0]    fwd_log[$];
    logic [MSG_W-1:0]    exp_log[$];
    int                  done_cnt, ack_len, ack_max;
    bit                  run_seen;

    // model state
    bit                  m_busy, m_settling, m_running, m_draining;
    bit                  m_run, m_ack, m_done, m_err, m_first;
    int                  m_settle_seen;
    logic [PARAMS_W-1:0] m_params;
    logic [CTR_W-1:0]    m_wc, m_wf;
    logic [MSG_W-1:0]    m_txd;
    logic [MSG_W-1:0]    m_buf[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input int a, input int d);
        return {ADDR_W'(a), DATA_W'(d)};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_settling = 0; m_running = 0; m_draining = 0;
        m_run = 0; m_ack = 0; m_done = 0; m_err = 0; m_first = 1;
        m_settle_seen = 0; m_params = '0; m_wc = '0; m_wf = '0; m_txd = '0;
        m_buf.delete();
    endtask

    task automatic model_step(input bit start, input bit stop, input logic [PARAMS_W-1:0] params,
                              input logic [CTR_W-1:0] wc, input bit mv,
                              input logic [MSG_W-1:0] msg, input bit ovr, input bit rdy);
        bit was_empty, hs, cap, hit;
        was_empty = (m_buf.size() == 0);
        hs  = !was_empty && rdy;
        cap = m_running && mv && !m_ack && (was_empty || hs);
        m_ack  = cap;
        m_done = 0;
        if (hs) begin
            void'(m_buf.pop_front());
            if (m_wf != {CTR_W{1'b1}}) m_wf = m_wf + 1'b1;
        end
        if (cap) begin
            if (!(m_first && DISCARD != 0)) begin
                m_buf.push_back(msg);
                m_txd = msg;
            end
            m_first = 0;
        end
        hit = hs && (m_wc != '0) && (m_wf == m_wc);
        if (!m_busy) begin
            if (start) begin
                m_params = params; m_wc = wc; m_err = 0; m_wf = '0; m_first = 1;
                m_busy = 1; m_settling = 1; m_settle_seen = 0;
            end
        end else if (m_settling) begin
            m_settle_seen++;
            if (stop) begin
                m_settling = 0; m_draining = 1;
            end else if (m_settle_seen == SETTLE) begin
                m_settling = 0; m_running = 1; m_run = 1;
            end
        end else if (m_running) begin
            if (stop || ovr || hit) begin
                m_running = 0; m_draining = 1; m_run = 0;
                if (ovr) m_err = 1;
            end
        end else if (m_draining) begin
            if (was_empty) begin
                m_draining = 0; m_busy = 0; m_done = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("run", bus.run, m_run);
        chk("mem_ack", bus.mem_ack, m_ack);
        chk("tx_valid", bus.tx_valid, m_buf.size() != 0);
        chk("tx_data", bus.tx_data, m_txd);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("error", bus.error, m_err);
        chk("words_forwarded", bus.words_forwarded, m_wf);
        chk("mem_params", bus.mem_params, m_params);
    endtask

    // One clock: called at a falling edge, checks, drives inputs for the next rising edge.
    task automatic cycle();
        bit mv;
        logic [MSG_W-1:0] head;
        compare_all();
        if (bus.done) done_cnt++;
        if (bus.run) run_seen = 1;
        if (bus.mem_ack) ack_len++; else ack_len = 0;
        if (ack_len > ack_max) ack_max = ack_len;
        if (bus.mem_ack && mgr_q.size() != 0) void'(mgr_q.pop_front());
        if (!bus.run) s_ovr = 0;
        head = (mgr_q.size() != 0) ? mgr_q[0] : '0;
        mv = (mgr_q.size() != 0) && bus.run && !bus.mem_ack;
        bus.cmd_start        = s_start;
        bus.cmd_stop         = s_stop;
        bus.cmd_params       = s_params;
        bus.cmd_word_count   = s_wc;
        bus.mem_valid        = mv;
        bus.mem_received_num = head;
        bus.mem_overrun      = s_ovr;
        bus.tx_ready         = s_rdy;
        if (bus.tx_valid && s_rdy) fwd_log.push_back(bus.tx_data);
        model_step(s_start, s_stop, s_params, s_wc, mv, head, s_ovr, s_rdy);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [CTR_W-1:0] wc, input logic [PARAMS_W-1:0] p);
        s_wc = wc; s_params = p; s_start = 1;
        cycle();
        s_start = 0;
    endtask

    task automatic pulse_stop();
        s_stop = 1;
        cycle();
        s_stop = 0;
    endtask

    task automatic wait_run(input string name, output int n);
        n = 0;
        while (bus.run !== 1'b1 && n < 100) begin cycle(); n++; end
        chk(name, bus.run, 1'b1);
    endtask

    task automatic wait_txv(input string name);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 100) begin cycle(); n++; end
        chk(name, bus.tx_valid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 400) begin cycle(); n++; end
        chk(name, bus.done, 1'b1);
    endtask

    task automatic chk_log(input string name);
        chk(name, fwd_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < fwd_log.size(); i++) chk(name, fwd_log[i], exp_log[i]);
    endtask

    task automatic new_scenario();
        fwd_log.delete(); exp_log.delete(); mgr_q.delete();
        done_cnt = 0; ack_len = 0; ack_max = 0; run_seen = 0;
    endtask

    initial begin
        int n;
        logic [CTR_W-1:0] wf0;
        rst = 0;
        s_start = 0; s_stop = 0; s_ovr = 0; s_rdy = 0; s_params = '0; s_wc = '0;
        bus.cmd_start = 0; bus.cmd_stop = 0; bus.cmd_params = '0; bus.cmd_word_count = '0;
        bus.mem_valid = 0; bus.mem_received_num = '0; bus.mem_overrun = 0; bus.tx_ready = 0;
        #1 rst = 1;
        @(negedge clk);
        chk("rst_run", bus.run, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_txv", bus.tx_valid, 0);
        chk("rst_wf", bus.words_forwarded, 0);
        chk("rst_params", bus.mem_params, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        new_scenario();
        cycle();

        // A: three words after a discarded first one
        new_scenario();
        for (int i = 0; i < 4; i++) mgr_q.push_back(mk(i, 16'hA000 + i));
        s_rdy = 1;
        pulse_start(16'd3, 32'hC0FF_EE01);
        wait_run("A_run", n);
        chk("A_run_latency", n + 1, 5);
        wait_done("A_done");
        chk("A_wf", bus.words_forwarded, 3);
        chk("A_error", bus.error, 0);
        chk("A_run_low", bus.run, 0);
        for (int i = 1; i < 4; i++) exp_log.push_back(mk(i, 16'hA000 + i));
        chk_log("A_log");
        repeat (4) cycle();
        chk("A_done_once", done_cnt, 1);

        // B: backpressure, then capture and handshake in the same cycle
        new_scenario();
        for (int i = 0; i < 4; i++) mgr_q.push_back(mk(16 + i, 16'hB000 + i));
        s_rdy = 0;
        pulse_start(16'd0, 32'h0000_B0B0);
        wait_txv("B_txv");
        for (int i = 0; i < 20; i++) begin
            chk("B_hold", bus.tx_data, mk(17, 16'hB001));
            cycle();
        end
        chk("B_ack_withheld", bus.mem_ack, 0);
        wf0 = bus.words_forwarded;
        s_rdy = 1;
        cycle();
        chk("B_same_txv", bus.tx_valid, 1);
        chk("B_same_data", bus.tx_data, mk(18, 16'hB002));
        chk("B_same_wf", bus.words_forwarded, wf0 + 1'b1);
        repeat (10) cycle();
        pulse_stop();
        wait_done("B_done");
        for (int i = 1; i < 4; i++) exp_log.push_back(mk(16 + i, 16'hB000 + i));
        chk_log("B_log");
        chk("B_ack_len", ack_max, 1);

        // C: overrun with a word buffered
        new_scenario();
        for (int i = 0; i < 3; i++) mgr_q.push_back(mk(32 + i, 16'hC000 + i));
        s_rdy = 0;
        pulse_start(16'd0, 32'h0000_C0C0);
        wait_txv("C_txv");
        s_ovr = 1;
        cycle();
        chk("C_run_low", bus.run, 0);
        chk("C_error", bus.error, 1);
        chk("C_buffered", bus.tx_valid, 1);
        s_rdy = 1;
        wait_done("C_done");
        exp_log.push_back(mk(33, 16'hC001));
        chk_log("C_log");
        cycle();
        chk("C_error_sticky", bus.error, 1);

        // D: stop during settle, start ignored while busy; new start clears error
        new_scenario();
        pulse_start(16'd5, 32'h0000_D001);
        chk("D_error_clr", bus.error, 0);
        pulse_start(16'd1, 32'h0000_DEAD);
        chk("D_params_kept", bus.mem_params, 32'h0000_D001);
        pulse_stop();
        wait_done("D_done_settle");
        chk("D_never_ran", run_seen, 0);

        // D2: stop during an unlimited run
        new_scenario();
        for (int i = 0; i < 3; i++) mgr_q.push_back(mk(48 + i, 16'hD000 + i));
        s_rdy = 1;
        pulse_start(16'd0, 32'h0000_D002);
        wait_run("D2_run", n);
        repeat (12) cycle();
        pulse_stop();
        chk("D2_run_low", bus.run, 0);
        wait_done("D2_done");
        for (int i = 1; i < 3; i++) exp_log.push_back(mk(48 + i, 16'hD000 + i));
        chk_log("D2_log");
        cycle();
        chk("D2_idle", bus.busy, 0);

        // E: asynchronous reset mid-run with a word held
        new_scenario();
        for (int i = 0; i < 4; i++) mgr_q.push_back(mk(64 + i, 16'hE000 + i));
        s_rdy = 1;
        pulse_start(16'd0, 32'h0000_E0E0);
        wait_run("E_run", n);
        repeat (6) cycle();
        s_rdy = 0;
        wait_txv("E_txv");
        rst = 1;
        #1;
        chk("E_rst_run", bus.run, 0);
        chk("E_rst_txv", bus.tx_valid, 0);
        chk("E_rst_busy", bus.busy, 0);
        chk("E_rst_wf", bus.words_forwarded, 0);
        chk("E_rst_done", bus.done, 0);
        bus.mem_valid = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        new_scenario();
        repeat (5) cycle();
        chk("E_no_done", done_cnt, 0);

        // F: random traffic against the model
        new_scenario();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                s_start = 1;
                s_wc = CTR_W'($urandom_range(0, 6));
                s_params = $urandom;
            end
            s_stop = ($urandom_range(0, 79) == 0);
            if (bus.run && $urandom_range(0, 99) == 0) s_ovr = 1;
            s_rdy = ($urandom_range(0, 3) != 0);
            if (mgr_q.size() < 2 && $urandom_range(0, 2) == 0) mgr_q.push_back(MSG_W'($urandom));
            cycle();
            s_start = 0;
            s_stop = 0;
        end
        s_rdy = 1;
        if (bus.busy) begin
            pulse_stop();
            if (bus.busy) wait_done("F_done");
        end
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
